// File: rtl/id_stage_pipelined_if.sv
// ID/EX pipeline boundary bundle.
// The decode stage drives it through the master modport.
// The execute stage reads it through the slave modport.
//   o_valid      - slot holds a real instruction (0 = bubble)
//   o_op         - opcode
//   o_reg_A/B    - forwarded rs/rt operands
//   o_immediate  - sign-extended 16-bit immediate
//   o_dir_rs/rt/rd - register addresses
//   o_jmp_direc  - 26-bit jump field
//   o_pc_next    - PC + 1
interface id_stage_pipelined_if #(
  parameter int SIZE         = 32,
  parameter int SIZE_REG_DIR = 5,
  parameter int SIZE_OP      = 6
);
  logic                    o_valid;
  logic [SIZE_OP-1:0]      o_op;
  logic [SIZE-1:0]         o_reg_A;
  logic [SIZE-1:0]         o_reg_B;
  logic [SIZE-1:0]         o_immediate;
  logic [SIZE_REG_DIR-1:0] o_dir_rs;
  logic [SIZE_REG_DIR-1:0] o_dir_rt;
  logic [SIZE_REG_DIR-1:0] o_dir_rd;
  logic [25:0]             o_jmp_direc;
  logic [SIZE-1:0]         o_pc_next;

  modport master (
    output o_valid, o_op, o_reg_A, o_reg_B, o_immediate,
           o_dir_rs, o_dir_rt, o_dir_rd, o_jmp_direc, o_pc_next
  );

  modport slave (
    input  o_valid, o_op, o_reg_A, o_reg_B, o_immediate,
           o_dir_rs, o_dir_rt, o_dir_rd, o_jmp_direc, o_pc_next
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// Pipelined MIPS decode stage.
// It contains the register file, N-source operand forwarding, load-use
// hazard detection and the registered ID/EX boundary.
// Ports:
//   clk, rst (async, active-low)
//   i_valid/i_instruction/i_pc       - IF/ID contents
//   i_stall, i_flush                 - pipeline control
//   i_write_enable/i_w_dir/i_w_data  - write-back port
//   i_fwd_wr/i_fwd_rd/i_fwd_data     - forwarding sources; index 0 is the youngest
//   i_mem_read_ex, i_rd_ex           - load currently in EX
//   o_stall                          - hold PC and IF/ID
//   o_branch_eq, o_branch_target     - combinational branch resolution
//   id_ex                            - registered ID/EX fields (master)
//   o_registers_debug                - flattened register file
module id_stage_pipelined #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS),
  parameter int SIZE_OP       = 6,
  parameter int NUM_FWD       = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  input  logic [SIZE-1:0]                i_instruction,
  input  logic [SIZE-1:0]                i_pc,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic                           i_write_enable,
  input  logic [SIZE_REG_DIR-1:0]        i_w_dir,
  input  logic [SIZE-1:0]                i_w_data,
  input  logic [NUM_FWD-1:0]             i_fwd_wr,
  input  logic [NUM_FWD*SIZE_REG_DIR-1:0] i_fwd_rd,
  input  logic [NUM_FWD*SIZE-1:0]        i_fwd_data,
  input  logic                           i_mem_read_ex,
  input  logic [SIZE_REG_DIR-1:0]        i_rd_ex,
  output logic                           o_stall,
  output logic                           o_branch_eq,
  output logic [SIZE-1:0]                o_branch_target,
  id_stage_pipelined_if.master           id_ex,
  output logic [SIZE*NUM_REGISTERS-1:0]  o_registers_debug
);

  localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

  logic [SIZE-1:0]         regs [NUM_REGISTERS];
  logic [SIZE_REG_DIR-1:0] rs, rt, rd;
  logic [SIZE_OP-1:0]      op;
  logic [SIZE-1:0]         imm;
  logic [SIZE-1:0]         pc_plus1;
  logic [SIZE-1:0]         op_a, op_b;
  logic                    hz;

  assign op  = i_instruction[31:26];
  assign rs  = i_instruction[21 +: SIZE_REG_DIR];
  assign rt  = i_instruction[16 +: SIZE_REG_DIR];
  assign rd  = i_instruction[11 +: SIZE_REG_DIR];
  assign imm = {{(SIZE-16){i_instruction[15]}}, i_instruction[15:0]};
  assign pc_plus1 = i_pc + ONE;

  // Register file; r0 is never written, so it always reads back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGISTERS; k++) regs[k] <= '0;
    end else if (i_write_enable && i_w_dir != '0) begin
      regs[i_w_dir] <= i_w_data;
    end
  end

  for (genvar g = 0; g < NUM_REGISTERS; g++) begin : g_dbg
    assign o_registers_debug[g*SIZE +: SIZE] = regs[g];
  end

  // Operand select: register file, then write-through, then forwarding.
  // The forwarding loop runs from oldest to youngest, so the lowest index wins.
  always_comb begin
    op_a = regs[rs];
    if (i_write_enable && i_w_dir == rs) op_a = i_w_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_wr[k] && i_fwd_rd[k*SIZE_REG_DIR +: SIZE_REG_DIR] == rs)
        op_a = i_fwd_data[k*SIZE +: SIZE];
    end
    if (rs == '0) op_a = '0;
  end

  always_comb begin
    op_b = regs[rt];
    if (i_write_enable && i_w_dir == rt) op_b = i_w_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_wr[k] && i_fwd_rd[k*SIZE_REG_DIR +: SIZE_REG_DIR] == rt)
        op_b = i_fwd_data[k*SIZE +: SIZE];
    end
    if (rt == '0) op_b = '0;
  end

  assign hz = i_valid & i_mem_read_ex & (i_rd_ex != '0) &
              ((i_rd_ex == rs) | (i_rd_ex == rt));

  assign o_stall         = hz | i_stall;
  assign o_branch_eq     = (op_a == op_b);
  assign o_branch_target = pc_plus1 + imm;

  // ID/EX register. The priority is flush, then stall, then hazard bubble, then load.
  // A flush or bubble clears only o_valid; the data fields keep their old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex.o_valid     <= 1'b0;
      id_ex.o_op        <= '0;
      id_ex.o_reg_A     <= '0;
      id_ex.o_reg_B     <= '0;
      id_ex.o_immediate <= '0;
      id_ex.o_dir_rs    <= '0;
      id_ex.o_dir_rt    <= '0;
      id_ex.o_dir_rd    <= '0;
      id_ex.o_jmp_direc <= '0;
      id_ex.o_pc_next   <= '0;
    end else if (i_flush) begin
      id_ex.o_valid <= 1'b0;
    end else if (i_stall) begin
      id_ex.o_valid <= id_ex.o_valid;
    end else if (hz) begin
      id_ex.o_valid <= 1'b0;
    end else begin
      id_ex.o_valid     <= i_valid;
      id_ex.o_op        <= op;
      id_ex.o_reg_A     <= op_a;
      id_ex.o_reg_B     <= op_b;
      id_ex.o_immediate <= imm;
      id_ex.o_dir_rs    <= rs;
      id_ex.o_dir_rt    <= rt;
      id_ex.o_dir_rd    <= rd;
      id_ex.o_jmp_direc <= i_instruction[25:0];
      id_ex.o_pc_next   <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
module tb_id_stage_pipelined;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [31:0]   i_instruction, i_pc;
  logic          i_stall, i_flush;
  logic          i_write_enable;
  logic [4:0]    i_w_dir;
  logic [31:0]   i_w_data;
  logic [2:0]    i_fwd_wr;
  logic [14:0]   i_fwd_rd;
  logic [95:0]   i_fwd_data;
  logic          i_mem_read_ex;
  logic [4:0]    i_rd_ex;
  logic          o_stall, o_branch_eq;
  logic [31:0]   o_branch_target;
  logic [1023:0] o_registers_debug;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage_pipelined_if #(.SIZE(32), .SIZE_REG_DIR(5), .SIZE_OP(6)) id_ex ();

  id_stage_pipelined dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc(i_pc), .i_stall(i_stall), .i_flush(i_flush),
    .i_write_enable(i_write_enable), .i_w_dir(i_w_dir), .i_w_data(i_w_data),
    .i_fwd_wr(i_fwd_wr), .i_fwd_rd(i_fwd_rd), .i_fwd_data(i_fwd_data),
    .i_mem_read_ex(i_mem_read_ex), .i_rd_ex(i_rd_ex), .o_stall(o_stall),
    .o_branch_eq(o_branch_eq), .o_branch_target(o_branch_target),
    .id_ex(id_ex.master), .o_registers_debug(o_registers_debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc;
    logic        we;
    logic [4:0]  w_dir;
    logic [31:0] w_data;
    logic [2:0]  fwd_wr;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic [31:0] exp_a, exp_b, exp_bt, exp_pcn;
    logic        exp_beq;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'd0, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic we, input logic [4:0] w_dir, input logic [31:0] w_data,
                              input logic [2:0] fwd_wr, input logic [4:0] rd0, input logic [4:0] rd1,
                              input logic [4:0] rd2, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] ebt, input logic [31:0] epcn, input logic ebeq);
    vec_t v;
    v.instr = instr; v.pc = pc; v.we = we; v.w_dir = w_dir; v.w_data = w_data;
    v.fwd_wr = fwd_wr; v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.exp_a = ea; v.exp_b = eb; v.exp_bt = ebt; v.exp_pcn = epcn; v.exp_beq = ebeq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b1; i_instruction = '0; i_pc = '0;
    i_stall = 1'b0; i_flush = 1'b0;
    i_write_enable = 1'b0; i_w_dir = '0; i_w_data = '0;
    i_fwd_wr = '0; i_fwd_rd = '0; i_fwd_data = '0;
    i_mem_read_ex = 1'b0; i_rd_ex = '0;

    vecs[0]  = mk(rtype(5,0,3), 32'h10, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0,
                  32'h12345678, 32'h0, 32'h1831, 32'h11, 1'b0);
    vecs[1]  = mk(rtype(6,6,1), 32'h0, 1, 6, 32'hCAFE0001, 3'b000, 0, 0, 0, 0, 0, 0,
                  32'hCAFE0001, 32'hCAFE0001, 32'h821, 32'h1, 1'b1);
    vecs[2]  = mk(rtype(0,6,2), 32'h0, 1, 0, 32'hDEAD, 3'b000, 0, 0, 0, 0, 0, 0,
                  32'h0, 32'hCAFE0001, 32'h1021, 32'h1, 1'b0);
    vecs[3]  = mk(rtype(7,5,4), 32'h0, 0, 0, 0, 3'b101, 7, 0, 7, 32'hAAAA, 0, 32'hBBBB,
                  32'hAAAA, 32'h12345678, 32'h2021, 32'h1, 1'b0);
    vecs[4]  = mk(rtype(7,5,4), 32'h0, 0, 0, 0, 3'b100, 7, 0, 7, 32'hAAAA, 0, 32'hBBBB,
                  32'hBBBB, 32'h12345678, 32'h2021, 32'h1, 1'b0);
    vecs[5]  = mk(rtype(0,5,4), 32'h0, 0, 0, 0, 3'b001, 0, 0, 0, 32'h5555, 0, 0,
                  32'h0, 32'h12345678, 32'h2021, 32'h1, 1'b0);
    vecs[6]  = mk(rtype(5,6,4), 32'h0, 1, 5, 32'h99990000, 3'b010, 0, 5, 0, 0, 32'h77770000, 0,
                  32'h77770000, 32'hCAFE0001, 32'h2021, 32'h1, 1'b0);
    vecs[7]  = mk(rtype(5,0,4), 32'h0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0,
                  32'h99990000, 32'h0, 32'h2021, 32'h1, 1'b0);
    vecs[8]  = mk(itype(6'h04,6,6,16'h0000), 32'hFFFFFFFF, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0,
                  32'hCAFE0001, 32'hCAFE0001, 32'h0, 32'h0, 1'b1);
    vecs[9]  = mk(itype(6'h04,5,6,16'hFFFE), 32'h20, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0,
                  32'h99990000, 32'hCAFE0001, 32'h1F, 32'h21, 1'b0);
    vecs[10] = mk(itype(6'h04,8,9,16'h0005), 32'h100, 0, 0, 0, 3'b011, 8, 9, 0, 32'h10, 32'h10, 0,
                  32'h10, 32'h10, 32'h106, 32'h101, 1'b1);

    // Reset state
    #1;
    check("rst_valid", {31'd0, id_ex.o_valid}, 32'h0);
    check("rst_reg_A", id_ex.o_reg_A, 32'h0);
    check("rst_pc_next", id_ex.o_pc_next, 32'h0);
    check("rst_debug_nz", {31'd0, |o_registers_debug}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Write-back of r5
    i_valid = 1'b0;
    i_write_enable = 1'b1; i_w_dir = 5'd5; i_w_data = 32'h12345678;
    tick();
    i_write_enable = 1'b0;
    i_valid = 1'b1;
    check("wb_r5", o_registers_debug[5*32 +: 32], 32'h12345678);

    // Table-driven decode vectors
    for (int i = 0; i < 11; i++) begin
      i_instruction = vecs[i].instr; i_pc = vecs[i].pc;
      i_write_enable = vecs[i].we; i_w_dir = vecs[i].w_dir; i_w_data = vecs[i].w_data;
      i_fwd_wr = vecs[i].fwd_wr;
      i_fwd_rd = {vecs[i].rd2, vecs[i].rd1, vecs[i].rd0};
      i_fwd_data = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      #1;
      check($sformatf("v%0d_branch_target", i), o_branch_target, vecs[i].exp_bt);
      check($sformatf("v%0d_branch_eq", i), {31'd0, o_branch_eq}, {31'd0, vecs[i].exp_beq});
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, id_ex.o_valid}, 32'h1);
      check($sformatf("v%0d_reg_A", i), id_ex.o_reg_A, vecs[i].exp_a);
      check($sformatf("v%0d_reg_B", i), id_ex.o_reg_B, vecs[i].exp_b);
      check($sformatf("v%0d_pc_next", i), id_ex.o_pc_next, vecs[i].exp_pcn);
    end
    i_write_enable = 1'b0; i_fwd_wr = '0;
    check("r0_stays_zero", o_registers_debug[31:0], 32'h0);
    check("r6_written", o_registers_debug[6*32 +: 32], 32'hCAFE0001);
    check("op_branch", {26'd0, id_ex.o_op}, 32'h4);
    check("imm_sext", id_ex.o_immediate, 32'h5);

    // Load-use hazard
    i_instruction = rtype(2,4,1); i_pc = 32'h40;
    i_mem_read_ex = 1'b1; i_rd_ex = 5'd4;
    #1;
    check("lu_stall", {31'd0, o_stall}, 32'h1);
    tick();
    check("lu_bubble_valid", {31'd0, id_ex.o_valid}, 32'h0);
    check("lu_bubble_hold_A", id_ex.o_reg_A, 32'h10);
    check("lu_bubble_hold_pcn", id_ex.o_pc_next, 32'h101);
    i_mem_read_ex = 1'b0;
    i_fwd_wr = 3'b001; i_fwd_rd = {5'd0, 5'd0, 5'd4}; i_fwd_data = {32'h0, 32'h0, 32'h4444};
    #1;
    check("lu_stall_clear", {31'd0, o_stall}, 32'h0);
    tick();
    check("lu_load_valid", {31'd0, id_ex.o_valid}, 32'h1);
    check("lu_load_B", id_ex.o_reg_B, 32'h4444);
    check("lu_load_dir_rt", {27'd0, id_ex.o_dir_rt}, 32'h4);
    check("lu_load_pcn", id_ex.o_pc_next, 32'h41);
    i_fwd_wr = '0;

    // A load into r0 never creates a hazard
    i_instruction = rtype(0,0,1); i_mem_read_ex = 1'b1; i_rd_ex = 5'd0;
    #1;
    check("rd_ex0_no_stall", {31'd0, o_stall}, 32'h0);
    i_mem_read_ex = 1'b0;

    // Flush together with stall
    i_instruction = rtype(5,6,7); i_pc = 32'h50;
    i_stall = 1'b1; i_flush = 1'b1;
    tick();
    check("fs_valid", {31'd0, id_ex.o_valid}, 32'h0);
    check("fs_hold_B", id_ex.o_reg_B, 32'h4444);
    check("fs_hold_rd", {27'd0, id_ex.o_dir_rd}, 32'h1);
    i_stall = 1'b0; i_flush = 1'b0;
    tick();
    check("reload_valid", {31'd0, id_ex.o_valid}, 32'h1);
    check("reload_A", id_ex.o_reg_A, 32'h99990000);
    check("reload_rd", {27'd0, id_ex.o_dir_rd}, 32'h7);

    // Stall alone holds everything for three cycles
    i_instruction = rtype(6,5,2); i_pc = 32'h60; i_stall = 1'b1;
    #1;
    check("stall_out", {31'd0, o_stall}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_valid", c), {31'd0, id_ex.o_valid}, 32'h1);
      check($sformatf("stall%0d_A", c), id_ex.o_reg_A, 32'h99990000);
      check($sformatf("stall%0d_rd", c), {27'd0, id_ex.o_dir_rd}, 32'h7);
      check($sformatf("stall%0d_pcn", c), id_ex.o_pc_next, 32'h51);
    end
    i_stall = 1'b0;

    // Flush together with a hazard
    i_instruction = rtype(3,5,4); i_flush = 1'b1; i_mem_read_ex = 1'b1; i_rd_ex = 5'd5;
    #1;
    check("fh_stall", {31'd0, o_stall}, 32'h1);
    tick();
    check("fh_valid", {31'd0, id_ex.o_valid}, 32'h0);
    i_flush = 1'b0; i_mem_read_ex = 1'b0;

    // Reset mid-run while stalled
    i_write_enable = 1'b1; i_w_dir = 5'd1; i_w_data = 32'h1111;
    tick();
    i_write_enable = 1'b0;
    check("r1_written", o_registers_debug[63:32], 32'h1111);
    i_instruction = rtype(1,5,9); i_pc = 32'h70;
    tick();
    check("pre_rst_valid", {31'd0, id_ex.o_valid}, 32'h1);
    i_stall = 1'b1; i_mem_read_ex = 1'b1; i_rd_ex = 5'd1;
    #2 rst = 1'b0;
    #1;
    check("mrst_valid", {31'd0, id_ex.o_valid}, 32'h0);
    check("mrst_reg_A", id_ex.o_reg_A, 32'h0);
    check("mrst_pcn", id_ex.o_pc_next, 32'h0);
    check("mrst_rd", {27'd0, id_ex.o_dir_rd}, 32'h0);
    check("mrst_debug_nz", {31'd0, |o_registers_debug}, 32'h0);
    check("mrst_stall_follows", {31'd0, o_stall}, 32'h1);
    @(negedge clk);
    rst = 1'b1; i_stall = 1'b0; i_mem_read_ex = 1'b0;
    i_instruction = rtype(1,0,3); i_pc = 32'h80;
    tick();
    check("post_rst_valid", {31'd0, id_ex.o_valid}, 32'h1);
    check("post_rst_r1", id_ex.o_reg_A, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
